sa_fifo_ctrl_rws_32x16: RTL and testbench

Valid/ready FIFO controller that drives the write and read ports of a 32x16 two-port RAM and consumes its registered-address read data.
- The RAM has 1-cycle read latency: the address is captured on re, and dout holds M[captured addr].
- The controller hides this latency behind a 2-entry output skid buffer, sustaining 1 push + 1 pop per cycle.
- Sits between a producer pipe stage and a consumer pipe stage; the RAM instance is external, wired port-to-port.

---
 rtl/sa_fifo_ctrl_rws_32x16.sv | 147 ++++++++++++++
 tb/tb_sa_fifo_ctrl_rws_32x16.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_fifo_ctrl_rws_32x16.sv
// sa_fifo_ctrl_rws_32x16: valid/ready FIFO controller for an external 32x16
// two-port RAM with a registered read address (1-cycle read latency).
// A 2-entry skid buffer behind the RAM read port hides that latency, so one
// push and one pop can both complete every cycle.
// Optional macro SA_FIFO_CTRL_WATERMARK_EN adds wm_clr / wm_lvl, a registered
// high-watermark of fifo_count.
module sa_fifo_ctrl_rws_32x16 #(
  parameter int unsigned DW    = 16,
  parameter int unsigned AW    = 5,
  parameter int unsigned DEPTH = 32
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  input  logic [DW-1:0] ram_dout,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic [31:0]   ram_pwrbus_ram_pd,
`ifdef SA_FIFO_CTRL_WATERMARK_EN
  input  logic          wm_clr,
  output logic [5:0]    wm_lvl,
`endif
  output logic [5:0]    fifo_count
);

  localparam int unsigned CW = 6;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] ram_cnt;
  logic [CW-1:0] ram_cnt_nxt;
  logic          inflight;
  logic [DW-1:0] skid0;
  logic [DW-1:0] skid1;
  logic [DW-1:0] skid0_nxt;
  logic [DW-1:0] skid1_nxt;
  logic [1:0]    skid_cnt;
  logic [1:0]    skid_cnt_nxt;
  logic          push;
  logic          pop;
  logic          issue;
  logic [2:0]    occ_after_pop;

  // Handshakes and read-issue decision
  assign push          = wr_pvld & wr_prdy;
  assign pop           = rd_pvld & rd_prdy;
  assign occ_after_pop = 3'(skid_cnt) + 3'(inflight) - 3'(pop);
  // Issue only while the skid buffer is guaranteed a free slot for the capture
  assign issue         = (ram_cnt != '0) && (occ_after_pop <= 3'd1);

  // RAM port drive and power-bus pass-through
  assign ram_we            = push;
  assign ram_wa            = wr_ptr;
  assign ram_di            = wr_pd;
  assign ram_re            = issue;
  assign ram_ra            = rd_ptr;
  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;
  assign rd_pd             = skid0;

  // Occupancy of the RAM after this cycle's push/issue
  always_comb begin
    ram_cnt_nxt = ram_cnt;
    case ({push, issue})
      2'b10:   ram_cnt_nxt = ram_cnt + CW'(1);
      2'b01:   ram_cnt_nxt = ram_cnt - CW'(1);
      default: ram_cnt_nxt = ram_cnt;
    endcase
  end

  // Skid buffer next state: pop shifts the queue, capture appends at the tail
  always_comb begin
    skid0_nxt    = skid0;
    skid1_nxt    = skid1;
    skid_cnt_nxt = skid_cnt - 2'(pop) + 2'(inflight);
    if (pop) begin
      skid0_nxt = skid1;
    end
    if (inflight) begin
      if (skid_cnt == 2'(pop)) begin
        skid0_nxt = ram_dout;
      end else begin
        skid1_nxt = ram_dout;
      end
    end
  end

  // Pointer, occupancy and handshake-flag registers
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      inflight   <= 1'b0;
      wr_prdy    <= 1'b0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      ram_cnt    <= ram_cnt_nxt;
      inflight   <= issue;
      wr_prdy    <= (ram_cnt_nxt < CW'(DEPTH));
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // Skid buffer storage and output-valid flag
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      skid0    <= '0;
      skid1    <= '0;
      skid_cnt <= '0;
      rd_pvld  <= 1'b0;
    end else begin
      skid0    <= skid0_nxt;
      skid1    <= skid1_nxt;
      skid_cnt <= skid_cnt_nxt;
      rd_pvld  <= (skid_cnt_nxt != 2'd0);
    end
  end

`ifdef SA_FIFO_CTRL_WATERMARK_EN
  // High-watermark of fifo_count; clear reloads the current level
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wm_lvl <= '0;
    end else if (wm_clr) begin
      wm_lvl <= fifo_count;
    end else if (fifo_count > wm_lvl) begin
      wm_lvl <= fifo_count;
    end
  end
`endif

endmodule

// File: tb/tb_sa_fifo_ctrl_rws_32x16.sv
// Self-checking bench for sa_fifo_ctrl_rws_32x16 with a behavioural RAM,
// a queue-based reference model checked every cycle, and directed tests
// with literal expectations.
module tb_sa_fifo_ctrl_rws_32x16;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset_;
  logic          wr_pvld;
  logic          wr_prdy;
  logic [DW-1:0] wr_pd;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic          ram_we;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_di;
  logic          ram_re;
  logic [AW-1:0] ram_ra;
  logic [DW-1:0] ram_dout;
  logic [31:0]   pwrbus_ram_pd;
  logic [31:0]   ram_pwrbus_ram_pd;
  logic [5:0]    fifo_count;
`ifdef SA_FIFO_CTRL_WATERMARK_EN
  logic          wm_clr;
  logic [5:0]    wm_lvl;
`endif

  sa_fifo_ctrl_rws_32x16 #(.DW(DW), .AW(AW), .DEPTH(32)) dut (
    .clk               (clk),
    .reset_            (reset_),
    .wr_pvld           (wr_pvld),
    .wr_prdy           (wr_prdy),
    .wr_pd             (wr_pd),
    .rd_pvld           (rd_pvld),
    .rd_prdy           (rd_prdy),
    .rd_pd             (rd_pd),
    .ram_we            (ram_we),
    .ram_wa            (ram_wa),
    .ram_di            (ram_di),
    .ram_re            (ram_re),
    .ram_ra            (ram_ra),
    .ram_dout          (ram_dout),
    .pwrbus_ram_pd     (pwrbus_ram_pd),
    .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd),
`ifdef SA_FIFO_CTRL_WATERMARK_EN
    .wm_clr            (wm_clr),
    .wm_lvl            (wm_lvl),
`endif
    .fifo_count        (fifo_count)
  );

  always #5 clk = ~clk;

  // Two-port RAM with registered read address
  logic [DW-1:0] mem [32];
  logic [AW-1:0] ra_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
  end
  assign ram_dout = mem[ra_q];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Reference model: ordered contents plus the cycle each word was accepted
  logic [DW-1:0] qd[$];
  int            qc[$];
  int            wcnt = 0;
  int            rcnt = 0;
  bit            prev_hi = 1'b0;
  bit            live;
  bit            exp_pvld;

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    cyc++;
    if (!reset_) begin
      chk("rst_wr_prdy", 32'(wr_prdy), 32'd0);
      chk("rst_rd_pvld", 32'(rd_pvld), 32'd0);
      chk("rst_ram_we", 32'(ram_we), 32'd0);
      chk("rst_ram_re", 32'(ram_re), 32'd0);
      chk("rst_count", 32'(fifo_count), 32'd0);
      qd.delete();
      qc.delete();
      wcnt    = 0;
      rcnt    = 0;
      prev_hi = 1'b0;
    end else begin
      live    = prev_hi;
      prev_hi = 1'b1;
      // A word becomes visible exactly 3 cycles after acceptance at the earliest
      exp_pvld = (qd.size() > 0) && (cyc - qc[0] >= 3);
      chk("m_count", 32'(fifo_count), 32'(qd.size()));
      chk("m_rd_pvld", 32'(rd_pvld), 32'(exp_pvld));
      if (rd_pvld && qd.size() > 0) chk("m_rd_pd", 32'(rd_pd), 32'(qd[0]));
      if (!live) chk("m_wr_prdy_first", 32'(wr_prdy), 32'd0);
      else if (qd.size() <= 31) chk("m_wr_prdy_room", 32'(wr_prdy), 32'd1);
      else if (qd.size() == 34) chk("m_wr_prdy_full", 32'(wr_prdy), 32'd0);
      chk("m_ram_we", 32'(ram_we), 32'(wr_pvld & wr_prdy));
      if (ram_we) begin
        chk("m_ram_wa", 32'(ram_wa), 32'(wcnt % 32));
        chk("m_ram_di", 32'(ram_di), 32'(wr_pd));
      end
      if (ram_re) begin
        chk("m_ram_ra", 32'(ram_ra), 32'(rcnt % 32));
        rcnt++;
      end
      chk("m_pwrbus", ram_pwrbus_ram_pd, pwrbus_ram_pd);
      if (rd_pvld && rd_prdy && qd.size() > 0) begin
        void'(qd.pop_front());
        void'(qc.pop_front());
      end
      if (wr_pvld && wr_prdy) begin
        qd.push_back(wr_pd);
        qc.push_back(cyc);
        wcnt++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int k;
  int cycles;
  int sent;
  int rcv;
  bit got_first;

  initial begin
`ifdef SA_FIFO_CTRL_WATERMARK_EN
    wm_clr = 1'b0;
`endif
    reset_        = 1'b0;
    wr_pvld       = 1'b0;
    wr_pd         = '0;
    rd_prdy       = 1'b0;
    pwrbus_ram_pd = 32'h1234_5678;

    // Reset release with no traffic
    repeat (3) @(negedge clk);
    chk("t1_count_in_reset", 32'(fifo_count), 32'd0);
    to_drive();
    reset_ = 1'b1;
    @(negedge clk);
    chk("t1_wr_prdy_lo", 32'(wr_prdy), 32'd0);
    @(negedge clk);
    chk("t1_wr_prdy_hi", 32'(wr_prdy), 32'd1);
    chk("t1_rd_pvld", 32'(rd_pvld), 32'd0);
    chk("t1_count", 32'(fifo_count), 32'd0);

    // Single word latency
    to_drive();
    wr_pvld = 1'b1;
    wr_pd   = 16'hA5A5;
    rd_prdy = 1'b1;
    @(negedge clk);
    chk("t2_we", 32'(ram_we), 32'd1);
    chk("t2_wa", 32'(ram_wa), 32'd0);
    to_drive();
    wr_pvld = 1'b0;
    @(negedge clk);
    chk("t2_re", 32'(ram_re), 32'd1);
    chk("t2_ra", 32'(ram_ra), 32'd0);
    @(negedge clk);
    chk("t2_pvld_t2", 32'(rd_pvld), 32'd0);
    @(negedge clk);
    chk("t2_pvld_t3", 32'(rd_pvld), 32'd1);
    chk("t2_pd", 32'(rd_pd), 32'h0000_A5A5);
    @(negedge clk);
    chk("t2_count_after", 32'(fifo_count), 32'd0);

    // Fill to 34 with the consumer stalled
    k = 0;
    cycles = 0;
    rd_prdy = 1'b0;
    while (k < 34 && cycles < 200) begin
      to_drive();
      wr_pvld = 1'b1;
      wr_pd   = 16'(k);
      @(negedge clk);
      if (wr_prdy) k++;
      cycles++;
    end
    chk("t3_accepted", 32'(k), 32'd34);
    to_drive();
    wr_pd = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_full_count", 32'(fifo_count), 32'd34);
      chk("t3_full_prdy", 32'(wr_prdy), 32'd0);
      chk("t3_full_we", 32'(ram_we), 32'd0);
    end

    // Drain 34 words back to back
    to_drive();
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      chk("t4_pvld", 32'(rd_pvld), 32'd1);
      chk("t4_pd", 32'(rd_pd), 32'(i));
    end
    @(negedge clk);
    chk("t4_pvld_end", 32'(rd_pvld), 32'd0);
    chk("t4_count_end", 32'(fifo_count), 32'd0);

    // Streaming: 100 words, no bubbles after the first output
    sent = 0;
    rcv = 0;
    got_first = 1'b0;
    cycles = 0;
    while (rcv < 100 && cycles < 300) begin
      to_drive();
      wr_pvld = (sent < 100);
      wr_pd   = 16'(16'h1000 + sent);
      rd_prdy = 1'b1;
      @(negedge clk);
      if (wr_pvld && wr_prdy) sent++;
      if (rd_pvld) begin
        chk("t5_pd", 32'(rd_pd), 32'(16'h1000 + rcv));
        rcv++;
        got_first = 1'b1;
      end else if (got_first) begin
        chk("t5_bubble", 32'(rd_pvld), 32'd1);
      end
      cycles++;
    end
    chk("t5_received", 32'(rcv), 32'd100);
    to_drive();
    wr_pvld = 1'b0;

    // Random traffic against the model
    k = 0;
    cycles = 0;
    while (k < 2000 && cycles < 20000) begin
      to_drive();
      wr_pvld       = 1'($urandom % 2);
      wr_pd         = 16'($urandom);
      rd_prdy       = 1'($urandom % 2);
      pwrbus_ram_pd = $urandom;
      @(negedge clk);
      if (wr_pvld && wr_prdy) k++;
      cycles++;
    end
    chk("t6_pushed", 32'(k), 32'd2000);
    to_drive();
    wr_pvld = 1'b0;
    rd_prdy = 1'b1;
    cycles = 0;
    @(negedge clk);
    while (fifo_count != 6'd0 && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    chk("t6_drained", 32'(fifo_count), 32'd0);

    // Reset mid-operation with 10 words held
    k = 0;
    cycles = 0;
    rd_prdy = 1'b0;
    while (k < 10 && cycles < 100) begin
      to_drive();
      wr_pvld = 1'b1;
      wr_pd   = 16'(16'h2000 + k);
      @(negedge clk);
      if (wr_prdy) k++;
      cycles++;
    end
    to_drive();
    wr_pvld = 1'b0;
    @(negedge clk);
    chk("t7_count10", 32'(fifo_count), 32'd10);
    to_drive();
    reset_ = 1'b0;
    #1;
    chk("t7_async_count", 32'(fifo_count), 32'd0);
    chk("t7_async_prdy", 32'(wr_prdy), 32'd0);
    chk("t7_async_pvld", 32'(rd_pvld), 32'd0);
    chk("t7_async_we", 32'(ram_we), 32'd0);
    chk("t7_async_re", 32'(ram_re), 32'd0);
    repeat (2) @(negedge clk);
    to_drive();
    reset_ = 1'b1;
    @(negedge clk);
    chk("t7_prdy_lo", 32'(wr_prdy), 32'd0);
    to_drive();
    wr_pvld = 1'b1;
    wr_pd   = 16'hBEEF;
    rd_prdy = 1'b1;
    @(negedge clk);
    chk("t7_we", 32'(ram_we), 32'd1);
    chk("t7_wa", 32'(ram_wa), 32'd0);
    to_drive();
    wr_pvld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t7_pvld_t2", 32'(rd_pvld), 32'd0);
    @(negedge clk);
    chk("t7_pvld_t3", 32'(rd_pvld), 32'd1);
    chk("t7_pd", 32'(rd_pd), 32'h0000_BEEF);
    @(negedge clk);
    chk("t7_empty", 32'(fifo_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
